// File: rtl/hyper_cfg_regs.sv
// hyper_cfg_regs
//   Register-bus slave holding the HyperBus controller configuration
//   (timing, address mapping, PHY selection). Software writes go to a
//   shadow copy; the shadow is committed to cfg_o only after the PHYs
//   have been idle for IdleCycles consecutive cycles, so a configuration
//   change never lands in the middle of a transaction.
//
//   Ports:
//     clk_i, rst_ni            clock, asynchronous active-low reset
//     reg_valid_i/write_i      request valid, 1 = write
//     reg_addr_i/wdata_i/wstrb_i  byte address, write data, byte strobes
//     reg_ready_o              one-cycle response strobe (1 cycle after valid)
//     reg_rdata_o/error_o      registered response data / error
//     trans_active_i           controller has a transaction in flight
//     cfg_o                    packed active config, fields from LSB in map order
//     cfg_pending_o            shadow holds an uncommitted write
//     cfg_commit_o             one-cycle pulse when cfg_o updates
//
//   Optional feature macro: HYPER_CFG_LOCK_EN adds a sticky write lock at 0x2C.

module hyper_cfg_regs #(
  parameter int unsigned RegAw      = 8,
  parameter int unsigned RegDw      = 32,
  parameter int unsigned NumPhys    = 2,
  parameter int unsigned IdleCycles = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_valid_i,
  input  logic               reg_write_i,
  input  logic [RegAw-1:0]   reg_addr_i,
  input  logic [RegDw-1:0]   reg_wdata_i,
  input  logic [RegDw/8-1:0] reg_wstrb_i,
  output logic               reg_ready_o,
  output logic [RegDw-1:0]   reg_rdata_o,
  output logic               reg_error_o,
  input  logic               trans_active_i,
  output logic [68:0]        cfg_o,
  output logic               cfg_pending_o,
  output logic               cfg_commit_o
);

  // Ten fields, 41 bits in total; the remaining cfg_o bits are tied to zero.
  localparam int unsigned CfgW = 41;
  localparam int unsigned CntW = (IdleCycles < 32'd1) ? 32'd1 : $clog2(IdleCycles + 32'd1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [RegAw-3:0] IDX_LAST_FLD = (RegAw-2)'(9);
  localparam logic [RegAw-3:0] IDX_STATUS   = (RegAw-2)'(10);
  localparam logic [RegAw-3:0] IDX_LOCK     = (RegAw-2)'(11);

  // MSB first: which_phy, phys_in_use, address_space, address_mask_msb,
  // t_tx, t_rx, t_rw_recovery, t_burst_max, en_latency_add, t_latency_access
  localparam logic [CfgW-1:0] CFG_RST = {1'b0, ((NumPhys == 32'd2) ? 1'b1 : 1'b0), 1'b0,
                                         5'd25, 4'd8, 4'd8, 4'd6, 16'd350, 1'b0, 4'd6};

  // Bit position of each field inside the packed config.
  function automatic int unsigned fld_lsb(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'd0;
      4'd1:    return 32'd4;
      4'd2:    return 32'd5;
      4'd3:    return 32'd21;
      4'd4:    return 32'd25;
      4'd5:    return 32'd29;
      4'd6:    return 32'd33;
      4'd7:    return 32'd38;
      4'd8:    return 32'd39;
      4'd9:    return 32'd40;
      default: return 32'd0;
    endcase
  endfunction

  // Field width; the PHY fields collapse to zero width on a single-PHY
  // build so they read 0 and swallow writes.
  function automatic int unsigned fld_width(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd4, 4'd5: return 32'd4;
      4'd1, 4'd7:             return 32'd1;
      4'd2:                   return 32'd16;
      4'd6:                   return 32'd5;
      4'd8, 4'd9:             return (NumPhys == 32'd2) ? 32'd1 : 32'd0;
      default:                return 32'd0;
    endcase
  endfunction

  function automatic logic [RegDw-1:0] fld_read(input logic [CfgW-1:0] cfg,
                                                input logic [3:0]      idx);
    logic [RegDw-1:0] word;
    int unsigned      lsb;
    int unsigned      w;
    word = '0;
    lsb  = fld_lsb(idx);
    w    = fld_width(idx);
    for (int unsigned i = 0; i < 32'd16; i++) begin
      if (i < w) word[i] = cfg[lsb + i];
    end
    return word;
  endfunction

  // Byte-strobed write of one field; bits outside the field are untouched.
  function automatic logic [CfgW-1:0] fld_write(input logic [CfgW-1:0]  cfg,
                                                input logic [3:0]       idx,
                                                input logic [RegDw-1:0] wdata,
                                                input logic [RegDw-1:0] bmask);
    logic [CfgW-1:0] nxt;
    int unsigned     lsb;
    int unsigned     w;
    nxt = cfg;
    lsb = fld_lsb(idx);
    w   = fld_width(idx);
    for (int unsigned i = 0; i < 32'd16; i++) begin
      if ((i < w) && bmask[i]) nxt[lsb + i] = wdata[i];
    end
    return nxt;
  endfunction

  logic [0:0]       state_r;
  logic             ready_r;
  logic [RegDw-1:0] rdata_r;
  logic             error_r;
  logic [CfgW-1:0]  shadow_r;
  logic [CfgW-1:0]  active_r;
  logic             pending_r;
  logic             commit_r;
  logic [CntW-1:0]  cnt_r;

  logic [RegAw-3:0] idx_s;
  logic [3:0]       fidx_s;
  logic [RegDw-1:0] bmask_s;
  logic             req_fire_s;
  logic             rsp_err_s;
  logic [RegDw-1:0] rsp_rdata_s;
  logic             shadow_wr_s;
  logic             apply_wr_s;
  logic [CfgW-1:0]  shadow_nxt_s;
  logic [CntW-1:0]  cnt_next_s;
  logic             commit_s;
  logic             locked_s;

  assign idx_s        = reg_addr_i[RegAw-1:2];
  assign fidx_s       = idx_s[3:0];
  assign req_fire_s   = reg_valid_i && (state_r == ST_IDLE);
  assign apply_wr_s   = req_fire_s && shadow_wr_s;
  assign shadow_nxt_s = fld_write(shadow_r, fidx_s, reg_wdata_i, bmask_s);
  assign commit_s     = pending_r && (cnt_next_s == CntW'(IdleCycles));

`ifdef HYPER_CFG_LOCK_EN
  logic lock_r;
  logic lock_set_s;
  assign locked_s = lock_r;
`else
  assign locked_s = 1'b0;
`endif

  // Expand byte strobes to a bit mask.
  always_comb begin
    bmask_s = '0;
    for (int b = 0; b < int'(RegDw / 8); b++) begin
      bmask_s[8*b +: 8] = {8{reg_wstrb_i[b]}};
    end
  end

  // Address decode: response data/error and write side effects of the request.
  always_comb begin
    rsp_err_s   = 1'b0;
    rsp_rdata_s = '0;
    shadow_wr_s = 1'b0;
`ifdef HYPER_CFG_LOCK_EN
    lock_set_s  = 1'b0;
`endif
    if (reg_addr_i[1:0] != 2'b00) begin
      rsp_err_s = 1'b1;
    end else if (idx_s <= IDX_LAST_FLD) begin
      if (reg_write_i) begin
        if (locked_s) begin
          rsp_err_s = 1'b1;
        end else begin
          shadow_wr_s = (fld_width(fidx_s) != 32'd0);
        end
      end else begin
        rsp_rdata_s = fld_read(shadow_r, fidx_s);
      end
    end else if (idx_s == IDX_STATUS) begin
      if (reg_write_i) begin
        rsp_err_s = locked_s;
      end else begin
        rsp_rdata_s = {{(RegDw-2){1'b0}}, trans_active_i, pending_r};
      end
    end
`ifdef HYPER_CFG_LOCK_EN
    else if (idx_s == IDX_LOCK) begin
      if (reg_write_i) begin
        if (locked_s) begin
          rsp_err_s = 1'b1;
        end else begin
          lock_set_s = reg_wstrb_i[0] & reg_wdata_i[0];
        end
      end else begin
        rsp_rdata_s = {{(RegDw-1){1'b0}}, lock_r};
      end
    end
`endif
    else begin
      rsp_err_s = 1'b1;
    end
  end

  // Saturating count of consecutive idle cycles, including the current one.
  always_comb begin
    if (trans_active_i) begin
      cnt_next_s = '0;
    end else if (cnt_r == CntW'(IdleCycles)) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CntW'(1);
    end
  end

  // Request/response FSM: capture in IDLE, present one ready pulse in RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      rdata_r <= '0;
      error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (reg_valid_i) begin
            state_r <= ST_RESP;
            ready_r <= 1'b1;
            rdata_r <= rsp_rdata_s;
            error_r <= rsp_err_s;
          end else begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          rdata_r <= '0;
          error_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          rdata_r <= '0;
          error_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow/active config, pending flag and commit pulse. A write landing in
  // the commit cycle goes to the shadow and keeps pending set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_r  <= CFG_RST;
      active_r  <= CFG_RST;
      pending_r <= 1'b0;
      commit_r  <= 1'b0;
      cnt_r     <= '0;
    end else begin
      cnt_r    <= cnt_next_s;
      commit_r <= commit_s;
      if (commit_s) active_r <= shadow_r;
      if (apply_wr_s) shadow_r <= shadow_nxt_s;
      if (apply_wr_s) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

`ifdef HYPER_CFG_LOCK_EN
  // Sticky lock bit: set by software, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_r <= 1'b0;
    end else if (req_fire_s && lock_set_s) begin
      lock_r <= 1'b1;
    end
  end
`endif

  assign reg_ready_o   = ready_r;
  assign reg_rdata_o   = rdata_r;
  assign reg_error_o   = error_r;
  assign cfg_o         = {{(69-CfgW){1'b0}}, active_r};
  assign cfg_pending_o = pending_r;
  assign cfg_commit_o  = commit_r;

endmodule

// File: tb/tb_hyper_cfg_regs.sv
// Self-checking bench for hyper_cfg_regs: directed register transactions,
// a field-level reference model, and a per-cycle compare of the config outputs.
module tb_hyper_cfg_regs;

  localparam int IdleCycles = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_valid_i;
  logic        reg_write_i;
  logic [7:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        trans_active_i;
  logic [68:0] cfg_o;
  logic        cfg_pending_o;
  logic        cfg_commit_o;

  hyper_cfg_regs #(.RegAw(8), .RegDw(32), .NumPhys(2), .IdleCycles(IdleCycles)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
    .trans_active_i(trans_active_i), .cfg_o(cfg_o),
    .cfg_pending_o(cfg_pending_o), .cfg_commit_o(cfg_commit_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [68:0] RST_LIT = 69'd6 | (69'd350 << 5) | (69'd6 << 21) | (69'd8 << 25) |
                                    (69'd8 << 29) | (69'd25 << 33) | (69'd1 << 39);

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int W   [10] = '{4, 1, 16, 4, 4, 4, 5, 1, 1, 1};
  int RST [10] = '{6, 0, 350, 6, 8, 8, 25, 0, 1, 0};
  logic [31:0] m_shadow [10];
  logic [31:0] m_active [10];
  bit m_pending, m_commit, m_busy, m_lock;
  int m_run;

  // 0 = config field, 1 = status, 2 = lock, 3 = unmapped
  function automatic int m_kind(input logic [7:0] a);
    if (a[1:0] != 2'b00) return 3;
    if (a < 8'h28) return 0;
    if (a == 8'h28) return 1;
`ifdef HYPER_CFG_LOCK_EN
    if (a == 8'h2C) return 2;
`endif
    return 3;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws, input int w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (ws[b]) r = (r & ~(32'hFF << (8 * b))) | (wd & (32'hFF << (8 * b)));
    return r & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [68:0] m_cfg();
    logic [68:0] v;
    int off;
    v = '0;
    off = 0;
    for (int i = 0; i < 10; i++) begin
      v = v | (69'(m_active[i]) << off);
      off += W[i];
    end
    return v;
  endfunction

  logic m_cap, m_wr_err, m_wr_ok, m_commit_now;
  assign m_cap        = reg_valid_i && !m_busy;
  assign m_wr_err     = (m_kind(reg_addr_i) == 3) || m_lock;
  assign m_wr_ok      = m_cap && reg_write_i && !m_wr_err;
  assign m_commit_now = m_pending && !trans_active_i && (m_run + 1 >= IdleCycles);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 10; i++) begin
        m_shadow[i] <= RST[i];
        m_active[i] <= RST[i];
      end
      m_pending <= 1'b0;
      m_commit  <= 1'b0;
      m_busy    <= 1'b0;
      m_lock    <= 1'b0;
      m_run     <= 0;
    end else begin
      m_busy   <= m_cap;
      m_commit <= m_commit_now;
      m_run    <= trans_active_i ? 0 : ((m_run < 1000) ? m_run + 1 : m_run);
      if (m_commit_now)
        for (int i = 0; i < 10; i++) m_active[i] <= m_shadow[i];
      if (m_wr_ok && m_kind(reg_addr_i) == 0)
        m_shadow[reg_addr_i / 4] <= m_merge(m_shadow[reg_addr_i / 4], reg_wdata_i,
                                            reg_wstrb_i, W[reg_addr_i / 4]);
      if (m_wr_ok && m_kind(reg_addr_i) == 0) m_pending <= 1'b1;
      else if (m_commit_now) m_pending <= 1'b0;
      if (m_wr_ok && m_kind(reg_addr_i) == 2 && reg_wstrb_i[0] && reg_wdata_i[0]) m_lock <= 1'b1;
    end
  end

  // Per-cycle compare of the config-side outputs against the model.
  always @(negedge clk_i) begin
    if (rst_ni && chk_en) begin
      check("cfg_o", cfg_o, m_cfg());
      check("cfg_pending_o", cfg_pending_o, m_pending);
      check("cfg_commit_o", cfg_commit_o, m_commit);
    end
  end

  // One register transaction; response expectations come from the model
  // state seen at the capture edge.
  task automatic xact(input bit wr, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] exp_rd;
    bit exp_er;
    @(negedge clk_i);
    reg_valid_i = 1'b1;
    reg_write_i = wr;
    reg_addr_i  = a;
    reg_wdata_i = wd;
    reg_wstrb_i = ws;
    exp_er = (m_kind(a) == 3) || (wr && m_lock);
    exp_rd = 32'd0;
    if (!wr && !exp_er) begin
      case (m_kind(a))
        0:       exp_rd = m_shadow[a / 4];
        1:       exp_rd = {30'd0, trans_active_i, m_pending};
        2:       exp_rd = {31'd0, m_lock};
        default: exp_rd = 32'd0;
      endcase
    end
    @(posedge clk_i);
    #1;
    check("ready_after_valid", reg_ready_o, 1'b1);
    check("resp_error", reg_error_o, exp_er);
    check("resp_rdata", reg_rdata_o, exp_rd);
    last_rdata  = reg_rdata_o;
    last_err    = reg_error_o;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ready_one_cycle", reg_ready_o, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    reg_addr_i = 8'h00;
    reg_wdata_i = 32'h0;
    reg_wstrb_i = 4'h0;
    trans_active_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_i);
    check("rst_cfg", cfg_o, RST_LIT);
    check("rst_pending", cfg_pending_o, 1'b0);
    check("rst_commit", cfg_commit_o, 1'b0);
    check("rst_ready", reg_ready_o, 1'b0);
    check("rst_rdata", reg_rdata_o, 32'd0);
    check("rst_error", reg_error_o, 1'b0);

    // reset values read back from the shadow
    xact(1'b0, 8'h00, 32'h0, 4'h0); check("rd_tlat", last_rdata, 32'd6);
    xact(1'b0, 8'h08, 32'h0, 4'h0); check("rd_burst", last_rdata, 32'd350);
    xact(1'b0, 8'h20, 32'h0, 4'h0); check("rd_phys", last_rdata, 32'd1);

    // write held off by an active transaction, committed after idle window
    @(negedge clk_i) trans_active_i = 1'b1;
    xact(1'b1, 8'h20, 32'h0, 4'hF);
    check("wr_phys_err", last_err, 1'b0);
    repeat (5) @(negedge clk_i);
    check("busy_pending", cfg_pending_o, 1'b1);
    check("busy_phys_held", cfg_o[39], 1'b1);
    trans_active_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("commit_pulse", cfg_commit_o, 1'b1);
    check("commit_phys", cfg_o[39], 1'b0);
    check("commit_pending_clr", cfg_pending_o, 1'b0);

    // byte strobes
    xact(1'b1, 8'h08, 32'h0000_1234, 4'b0001);
    xact(1'b0, 8'h08, 32'h0, 4'h0); check("wstrb_b0", last_rdata, 32'h0134);
    xact(1'b1, 8'h08, 32'h0000_ABCD, 4'b0010);
    xact(1'b0, 8'h08, 32'h0, 4'h0); check("wstrb_b1", last_rdata, 32'hAB34);
    repeat (3) @(negedge clk_i);
    check("burst_active", cfg_o[20:5], 16'hAB34);

    // unmapped / misaligned / status
    xact(1'b0, 8'h30, 32'h0, 4'h0); check("rd_0x30_err", last_err, 1'b1);
    xact(1'b0, 8'h05, 32'h0, 4'h0); check("rd_0x05_err", last_err, 1'b1);
    xact(1'b1, 8'h30, 32'hFFFF_FFFF, 4'hF); check("wr_0x30_err", last_err, 1'b1);
    xact(1'b1, 8'h05, 32'hFFFF_FFFF, 4'hF); check("wr_0x05_err", last_err, 1'b1);
    xact(1'b1, 8'h28, 32'hFFFF_FFFF, 4'hF); check("wr_status_err", last_err, 1'b0);
    check("bad_wr_no_pending", cfg_pending_o, 1'b0);
    @(negedge clk_i) trans_active_i = 1'b1;
    xact(1'b0, 8'h28, 32'h0, 4'h0); check("status_rd", last_rdata, 32'd2);

    // write in the commit cycle of an earlier write
    xact(1'b1, 8'h00, 32'd5, 4'hF);
    @(negedge clk_i) trans_active_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    reg_valid_i = 1'b1; reg_write_i = 1'b1; reg_addr_i = 8'h00;
    reg_wdata_i = 32'd9; reg_wstrb_i = 4'hF;
    @(posedge clk_i);
    #1;
    check("cc_commit", cfg_commit_o, 1'b1);
    check("cc_tlat_first", cfg_o[3:0], 4'd5);
    check("cc_pending_kept", cfg_pending_o, 1'b1);
    check("cc_ready", reg_ready_o, 1'b1);
    reg_valid_i = 1'b0; reg_write_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("cc_commit2", cfg_commit_o, 1'b1);
    check("cc_tlat_second", cfg_o[3:0], 4'd9);
    check("cc_pending_clr", cfg_pending_o, 1'b0);

    // trans_active stuck high holds the commit off
    @(negedge clk_i) trans_active_i = 1'b1;
    xact(1'b1, 8'h0C, 32'd2, 4'hF);
    repeat (20) @(negedge clk_i);
    check("stuck_pending", cfg_pending_o, 1'b1);
    check("stuck_rwr_held", cfg_o[24:21], 4'd6);
    trans_active_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("stuck_rwr_commit", cfg_o[24:21], 4'd2);

`ifdef HYPER_CFG_LOCK_EN
    @(negedge clk_i) trans_active_i = 1'b1;
    xact(1'b1, 8'h10, 32'd3, 4'hF);
    xact(1'b1, 8'h2C, 32'd1, 4'hF); check("lock_wr_ok", last_err, 1'b0);
    check("lock_pending", cfg_pending_o, 1'b1);
    @(negedge clk_i) trans_active_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("lock_commit_done", cfg_o[28:25], 4'd3);
    xact(1'b0, 8'h2C, 32'h0, 4'h0); check("lock_rd", last_rdata, 32'd1);
    xact(1'b1, 8'h00, 32'd3, 4'hF); check("locked_wr_err", last_err, 1'b1);
    xact(1'b0, 8'h00, 32'h0, 4'h0); check("locked_rd_prior", last_rdata, 32'd9);
    check("locked_no_pending", cfg_pending_o, 1'b0);
`else
    xact(1'b1, 8'h2C, 32'd1, 4'hF); check("nolock_wr_err", last_err, 1'b1);
    xact(1'b0, 8'h2C, 32'h0, 4'h0); check("nolock_rd_err", last_err, 1'b1);
`endif

    // reset while a response is being presented
    @(negedge clk_i);
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 8'h00;
    @(posedge clk_i);
    #1;
    check("mid_ready_before", reg_ready_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("mid_ready_abandoned", reg_ready_o, 1'b0);
    check("mid_cfg_reset", cfg_o, RST_LIT);
    check("mid_pending_reset", cfg_pending_o, 1'b0);
    reg_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid_ready_low", reg_ready_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_ready", reg_ready_o, 1'b0);
    xact(1'b0, 8'h00, 32'h0, 4'h0); check("post_rst_tlat", last_rdata, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
